// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, oversampling constants and the bit-period helper for the UART receiver
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} rx_state_t;
    localparam int OVERSAMPLE_SHIFT = 4;
    localparam int CPB_W = 20;
    // A divisor of 0 behaves as 1 so the bit period can never collapse to zero
    function automatic logic [CPB_W-1:0] calc_cpb(input logic [15:0] dbr);
        return {4'b0, (dbr == 16'd0) ? 16'd1 : dbr} << OVERSAMPLE_SHIFT;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count and overrun pulse
// Ports: clk, reset (sync, active-high); push/wr_data write side; pop/rd_data/rd_valid FWFT read side;
//        count = occupancy, count_nxt = occupancy after this cycle's update; overrun = dropped-push pulse.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_nxt,
    output logic             overrun
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign rd_valid = count != '0;
    assign do_pop = pop && rd_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign rd_data = rd_valid ? mem[rptr] : '0;
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wr_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            overrun <= 1'b0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count_nxt;
            overrun <= push && !do_push;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (8N1+, LSB first) feeding a FWFT FIFO with RTS flow control
// Ports: clk, reset (sync, active-high); rxd async serial in; dbr bit divisor (CPB = dbr<<4, 0 means 1);
//        rd_en/rd_data/rd_valid/fifo_count FIFO read side; rts_n = 1 asks the sender to hold off;
//        frame_err/overrun_err one-cycle error pulses; busy = receiver mid-frame.
// Build option: UART_RX_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronizer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RTS_THRESHOLD = 12,
    localparam int CW = $clog2(FIFO_DEPTH) + 1,
    localparam int IW = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic [15:0]           dbr,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [CW-1:0]         fifo_count,
    output logic                  rts_n,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);
    logic rx_meta, rxs, rx;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs <= rx_meta;
        end
    end
`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= 2'b11;
            rx <= 1'b1;
        end else begin
            hist <= {hist[0], rxs};
            rx <= (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
        end
    end
`else
    assign rx = rxs;
`endif
    rx_state_t state, state_n;
    logic [CPB_W-1:0] cnt, cnt_n, cpb, cpb_n;
    logic [DATA_WIDTH-1:0] sh, sh_n;
    logic [IW-1:0] idx, idx_n;
    logic push, ferr_n;
    logic [CW-1:0] count_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            cpb <= '0;
            sh <= '0;
            idx <= '0;
            frame_err <= 1'b0;
            rts_n <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            cpb <= cpb_n;
            sh <= sh_n;
            idx <= idx_n;
            frame_err <= ferr_n;
            rts_n <= count_nxt >= CW'(RTS_THRESHOLD);
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        cpb_n = cpb;
        sh_n = sh;
        idx_n = idx;
        push = 1'b0;
        ferr_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx) begin
                    state_n = START;
                    cpb_n = calc_cpb(dbr);
                end
            end
            START:
                // Mid-start-bit check: a line back high here was noise
                if (cnt == (cpb >> 1) - 1'b1) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rx ? IDLE : DATA;
                end
            DATA:
                if (cnt == cpb - 1'b1) begin
                    cnt_n = '0;
                    sh_n = {rx, sh[DATA_WIDTH-1:1]};
                    idx_n = idx + 1'b1;
                    if (idx == IW'(DATA_WIDTH - 1)) state_n = STOP;
                end
            STOP:
                if (cnt == cpb - 1'b1) begin
                    cnt_n = '0;
                    push = rx;
                    ferr_n = !rx;
                    state_n = rx ? IDLE : BRK_WAIT;
                end
            BRK_WAIT: begin
                // Absorb a held-low line so a break reports only one frame error
                cnt_n = '0;
                if (rx) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .wr_data(sh_n),
        .pop(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .count(fifo_count),
        .count_nxt(count_nxt),
        .overrun(overrun_err)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for the UART receiver FIFO
module tb_uart_rx_fifo;
    logic clk = 0, reset = 1, rxd = 1, rd_en = 0;
    logic [15:0] dbr = 16'd1;
    logic [7:0] rd_data;
    logic rd_valid, rts_n, frame_err, overrun_err, busy;
    logic [4:0] fifo_count;
    int n_chk = 0, n_fail = 0, ferr_cnt = 0, ovr_cnt = 0, cycles;
    logic busy_seen = 0;
    logic [7:0] q[$];

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .rxd(rxd), .dbr(dbr), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .rts_n(rts_n), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int nstop, input logic stopbit);
        rxd = 0;
        wait_clk(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(16);
        end
        rxd = stopbit;
        wait_clk(16 * nstop);
    endtask

    task automatic drain();
        rd_en = 1;
        for (int i = 0; i < 40 && rd_valid; i++) wait_clk(1);
        rd_en = 0;
        check("drain_count", fifo_count, 0);
        check("sb_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) ferr_cnt++;
            if (overrun_err) ovr_cnt++;
            if (busy) busy_seen = 1;
            if (rd_en && rd_valid) begin
                if (q.size() == 0) check("unexpected_pop", {24'b0, rd_data}, 32'hFFFF_FFFF);
                else check("pop_data", {24'b0, rd_data}, {24'b0, q.pop_front()});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        wait_clk(3);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rts", rts_n, 1);
        check("rst_busy", busy, 0);
        check("rst_errs", {frame_err, overrun_err}, 0);
        reset = 0;
        wait_clk(1);
        check("rts_after_rst", rts_n, 0);

        q.push_back(8'hA5);
        cycles = 0;
        fork
            send(8'hA5, 3, 1);
            while (!rd_valid && cycles < 300) begin
                wait_clk(1);
                cycles++;
            end
        join
        check("latency", (cycles >= 154 && cycles <= 156), 1);
        check("a5_flags", ferr_cnt + ovr_cnt, 0);
        drain();

        busy_seen = 0;
        rxd = 0;
        wait_clk(4);
        rxd = 1;
        wait_clk(30);
        check("false_start_busy_seen", busy_seen, 1);
        check("false_start_busy", busy, 0);
        check("false_start_count", fifo_count, 0);
        check("false_start_ferr", ferr_cnt, 0);

`ifdef UART_RX_GLITCH_FILTER_EN
        busy_seen = 0;
        rxd = 0;
        wait_clk(1);
        rxd = 1;
        wait_clk(20);
        check("glitch_no_busy", busy_seen, 0);
`endif

        send(8'h3C, 1, 0);
        wait_clk(100);
        rxd = 1;
        wait_clk(20);
        check("break_ferr", ferr_cnt, 1);
        check("break_count", fifo_count, 0);
        q.push_back(8'h55);
        send(8'h55, 1, 1);
        wait_clk(4);
        drain();
        check("break_ferr_after", ferr_cnt, 1);

        for (int i = 0; i < 17; i++) begin
            if (i < 16) q.push_back(i[7:0]);
            send(i[7:0], 1, 1);
            if (i == 10) check("rts_at_11", rts_n, 0);
            if (i == 11) check("rts_at_12", rts_n, 1);
        end
        wait_clk(2);
        check("full_count", fifo_count, 16);
        check("overrun_cnt", ovr_cnt, 1);

        q.push_back(8'h77);
        fork
            send(8'h77, 1, 1);
            begin
                wait_clk(154);
                rd_en = 1;
                wait_clk(1);
                rd_en = 0;
            end
        join
        wait_clk(2);
        check("pushpop_overrun", ovr_cnt, 1);
        check("pushpop_count", fifo_count, 16);
        drain();
        check("rts_empty", rts_n, 0);

        fork
            send(8'hFF, 1, 1);
            begin
                wait_clk(60);
                reset = 1;
                wait_clk(2);
                reset = 0;
            end
        join
        wait_clk(4);
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_busy", busy, 0);
        q.push_back(8'h81);
        send(8'h81, 1, 1);
        wait_clk(4);
        check("after_rst_count", fifo_count, 1);
        drain();
        check("final_ferr", ferr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
